// File: rtl/aha_sram_ctrl_pkg.sv
// Shared types and helpers for the AHB-Lite to single-port SRAM controller.
package aha_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_DEFER,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Lanes covered by a 2^hsize access, start aligned down to the access size.
  function automatic logic [7:0] byte_strb(input logic [2:0] hsize, input logic [2:0] addr);
    logic [7:0] s;
    case (hsize)
      3'd0:    s = 8'h01 << addr;
      3'd1:    s = 8'h03 << {addr[2:1], 1'b0};
      3'd2:    s = 8'h0F << {addr[2], 2'b00};
      3'd3:    s = 8'hFF;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aha_ahb_sram_ctrl.sv
// AHB-Lite subordinate for one single-port SRAM macro; zero-wait accesses with a
// single wait state when a read address phase collides with a write data phase.
module aha_ahb_sram_ctrl
  import aha_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    HSEL,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    SRAM_CEn,
  output logic [DATA_WIDTH/8-1:0] SRAM_WEn,
  output logic [ADDR_WIDTH-1:0]   SRAM_A,
  output logic [DATA_WIDTH-1:0]   SRAM_D,
  input  logic [DATA_WIDTH-1:0]   SRAM_Q
);

  localparam int LANES = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [LANES-1:0]        strb_q, strb_d;

  logic                    accept;
  logic                    size_err;
  logic                    port_free;
  logic                    rd_now;
  logic [ADDR_WIDTH-1:0]   haddr_word;
  logic                    unused_ok;

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign size_err   = HSIZE[2];
  assign haddr_word = HADDR[ADDR_WIDTH+2:3];
  assign unused_ok  = ^{HADDR[31:ADDR_WIDTH+3], HTRANS[0]};

  // The port is ours for an address-phase read only when no write data phase is active.
  assign port_free = (state_q == ST_IDLE) || (state_q == ST_RD_DATA) || (state_q == ST_ERR2);
  assign rd_now    = accept & ~HWRITE & ~size_err & port_free;

  always_comb begin
    state_d     = state_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    strb_d      = strb_q;
    case (state_q)
      ST_RD_DEFER: state_d = ST_RD_DATA;
      ST_ERR1:     state_d = ST_ERR2;
      default: begin
        if (accept) begin
          if (size_err) begin
            state_d = ST_ERR1;
          end else if (HWRITE) begin
            state_d = ST_WR_DATA;
            waddr_d = haddr_word;
            strb_d  = byte_strb(HSIZE, HADDR[2:0]);
          end else if (state_q == ST_WR_DATA) begin
            state_d = ST_RD_DEFER;
            raddr_d = haddr_word;
          end else begin
            state_d = ST_RD_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    case (state_d)
      ST_RD_DEFER: hreadyout_d = 1'b0;
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ST_ERR2:     hresp_d = HRESP_ERROR;
      default:     hreadyout_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  always_ff @(posedge CLK) begin
    waddr_q <= waddr_d;
    raddr_q <= raddr_d;
    strb_q  <= strb_d;
  end

  // SRAM port mux; held quiet while reset is asserted so an in-flight write is dropped.
  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = '1;
    SRAM_A   = '0;
    if (!RESET) begin
      case (state_q)
        ST_WR_DATA: begin
          SRAM_CEn = 1'b0;
          SRAM_WEn = ~strb_q;
          SRAM_A   = waddr_q;
        end
        ST_RD_DEFER: begin
          SRAM_CEn = 1'b0;
          SRAM_A   = raddr_q;
        end
        default: begin
          if (rd_now) begin
            SRAM_CEn = 1'b0;
            SRAM_A   = haddr_word;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = SRAM_Q;
  assign SRAM_D    = HWDATA;

endmodule

// File: tb/tb_aha_ahb_sram_ctrl.sv
// Directed bench for aha_ahb_sram_ctrl with a behavioural 4Kx64 SRAM macro model.
module tb_aha_ahb_sram_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA;
  wire         HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic        SRAM_CEn;
  logic [7:0]  SRAM_WEn;
  logic [11:0] SRAM_A;
  logic [63:0] SRAM_D;
  logic [63:0] SRAM_Q;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] mem [0:4095];

  assign HREADY = HREADYOUT;

  always #5 CLK = ~CLK;

  aha_ahb_sram_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) dut (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAM_CEn(SRAM_CEn), .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A),
    .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {4{16'hC000 | 16'(i)}};
    SRAM_Q = '0;
  end

  always @(posedge CLK) begin
    if (!SRAM_CEn) begin
      for (int b = 0; b < 8; b++)
        if (!SRAM_WEn[b]) mem[SRAM_A][b*8 +: 8] <= SRAM_D[b*8 +: 8];
      if (&SRAM_WEn) SRAM_Q <= mem[SRAM_A];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic sel, input logic wr, input logic [31:0] addr,
                     input logic [2:0] size);
    HSEL   = sel;
    HTRANS = sel ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] wd(input int k);
    return 64'hA5A5_0000_0000_0000 | 64'(k);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    RESET  = 1'b1;
    HWDATA = '0;
    bus(0, 0, 0, 3);
    repeat (2) @(posedge CLK);
    #3;
    chk("rst_hready", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp",  64'(HRESP),     64'd0);
    chk("rst_cen",    64'(SRAM_CEn),  64'd1);
    chk("rst_wen",    64'(SRAM_WEn),  64'hFF);
    chk("rst_a",      64'(SRAM_A),    64'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // reset asserted during the data phase of a write to word 0x10
    bus(1, 1, 32'h80, 3);
    cyc();
    bus(0, 0, 0, 3);
    HWDATA = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("t1_wen_before", 64'(SRAM_WEn), 64'h00);
    RESET = 1'b1;
    #1;
    chk("t1_cen",    64'(SRAM_CEn),  64'd1);
    chk("t1_wen",    64'(SRAM_WEn),  64'hFF);
    chk("t1_hready", 64'(HREADYOUT), 64'd1);
    cyc();
    RESET = 1'b0;
    bus(1, 0, 32'h80, 3);
    cyc();
    bus(0, 0, 0, 3);
    #2;
    chk("t1_old", HRDATA, 64'hC010_C010_C010_C010);

    // full-word write then read back
    cyc();
    bus(1, 1, 32'h80, 3);
    cyc();
    bus(0, 0, 0, 3);
    HWDATA = 64'hDEAD_BEEF_0123_4567;
    #2;
    chk("t2_wen", 64'(SRAM_WEn), 64'h00);
    chk("t2_wa",  64'(SRAM_A),   64'h010);
    cyc();
    bus(1, 0, 32'h80, 3);
    #2;
    chk("t2_rcen", 64'(SRAM_CEn), 64'd0);
    chk("t2_ra",   64'(SRAM_A),   64'h010);
    cyc();
    bus(0, 0, 0, 3);
    #2;
    chk("t2_hready", 64'(HREADYOUT), 64'd1);
    chk("t2_data",   HRDATA, 64'hDEAD_BEEF_0123_4567);

    // byte write to lane 5
    cyc();
    bus(1, 1, 32'h85, 0);
    cyc();
    bus(0, 0, 0, 3);
    HWDATA = 64'h0000_AA00_0000_0000;
    #2;
    chk("t3_wen", 64'(SRAM_WEn), 64'hDF);
    cyc();
    bus(1, 0, 32'h80, 3);
    cyc();
    bus(0, 0, 0, 3);
    #2;
    chk("t3_data", HRDATA, 64'hDEAD_AAEF_0123_4567);

    // write immediately followed by read of the same word
    cyc();
    bus(1, 1, 32'h100, 3);
    cyc();
    HWDATA = 64'hCAFE_F00D_1357_9BDF;
    bus(1, 0, 32'h100, 3);
    #2;
    chk("t4_hready_wr", 64'(HREADYOUT), 64'd1);
    cyc();
    bus(0, 0, 0, 3);
    #2;
    chk("t4_defer",   64'(HREADYOUT), 64'd0);
    chk("t4_def_cen", 64'(SRAM_CEn),  64'd0);
    chk("t4_def_wen", 64'(SRAM_WEn),  64'hFF);
    chk("t4_def_a",   64'(SRAM_A),    64'h020);
    cyc();
    #2;
    chk("t4_hready_rd", 64'(HREADYOUT), 64'd1);
    chk("t4_data",      HRDATA, 64'hCAFE_F00D_1357_9BDF);

    // illegal size
    cyc();
    bus(1, 0, 32'h0, 3'b100);
    #2;
    chk("t5_cen", 64'(SRAM_CEn), 64'd1);
    cyc();
    bus(0, 0, 0, 3);
    #2;
    chk("t5_err1_rdy",  64'(HREADYOUT), 64'd0);
    chk("t5_err1_resp", 64'(HRESP),     64'd1);
    chk("t5_err1_cen",  64'(SRAM_CEn),  64'd1);
    cyc();
    bus(1, 0, 32'h0, 3);
    #2;
    chk("t5_err2_rdy",  64'(HREADYOUT), 64'd1);
    chk("t5_err2_resp", 64'(HRESP),     64'd1);
    cyc();
    bus(0, 0, 0, 3);
    #2;
    chk("t5_next_resp", 64'(HRESP), 64'd0);
    chk("t5_next_data", HRDATA, 64'hC000_C000_C000_C000);

    // ten back-to-back writes, then ten reads
    lows = 0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      if (c < 10) begin
        bus(1, 1, 32'(8 * c), 3);
        if (c > 0) HWDATA = wd(c - 1);
      end else if (c == 10) begin
        bus(1, 0, 32'h0, 3);
        HWDATA = wd(9);
      end else if (c <= 20) begin
        bus(1, 0, 32'(8 * ((c == 11) ? 1 : (c - 11))), 3);
      end else begin
        bus(0, 0, 0, 3);
      end
      #2;
      if (!HREADYOUT) lows++;
      if (c == 11) chk("t6_defer", 64'(HREADYOUT), 64'd0);
      if (c >= 12) chk($sformatf("t6_rd%0d", c - 12), HRDATA, wd(c - 12));
    end
    chk("t6_stalls", 64'(lows), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
